// File: rtl/spi_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// spi_regfile_arbiter
//
// Shares one single-port synchronous register memory between two requesters:
//   * the SPI slave, whose write/read strobes come from the sck domain and are
//     synchronised here;
//   * a core-side req/gnt port.
// The block owns every mem_* control. At most one access is issued per cycle.
// A read parks the FSM in a wait state for one cycle while the memory returns
// data, and no new access is issued during that cycle.
//
// Optional feature (compile-time macro ARB_ROUND_ROBIN_EN):
//   defined   - when SPI and core contend in IDLE, the side that lost the last
//               contended access wins; after reset SPI is favoured.
//   undefined - fixed priority, SPI always wins.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   spi_addr_i/spi_write_data_i  SPI address / write data (sck domain, stable)
//   spi_write_en_i/spi_read_en_i SPI strobes (sck domain)
//   spi_read_data_o              SPI read data, held until the next SPI read
//   spi_overrun_o                sticky: an SPI op was lost or dropped
//   core_req_i/core_we_i         core request (held until granted) / write
//   core_addr_i/core_wdata_i     core address / write data
//   core_gnt_o                   combinational grant, access issued this cycle
//   core_rvalid_o/core_rdata_o   one-cycle read-data-valid pulse / read data
//   mem_addr_o/mem_wdata_o       memory address / write data (0 when idle)
//   mem_we_o/mem_re_o            memory write / read enable (never both)
//   mem_rdata_i                  memory read data, one cycle after mem_re_o
// -----------------------------------------------------------------------------
module spi_regfile_arbiter #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] spi_addr_i,
  input  logic [DATA_WIDTH-1:0] spi_write_data_i,
  input  logic                  spi_write_en_i,
  input  logic                  spi_read_en_i,
  output logic [DATA_WIDTH-1:0] spi_read_data_o,
  output logic                  spi_overrun_o,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPI_RD_WAIT,
    ST_CORE_RD_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // ---------------------------------------------------------------------------
  // Strobe synchronisers and rising-edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic                   r_wr_dly;
  logic                   r_rd_dly;
  logic                   w_wr_det;
  logic                   w_rd_det;
  logic                   w_spi_det;

  // NOTE: sequential state is always assigned with <=, so every flop samples
  // the pre-edge value of its neighbours and the chain shifts by one stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_sync <= '0;
      r_rd_sync <= '0;
      r_wr_dly  <= 1'b0;
      r_rd_dly  <= 1'b0;
    end else begin
      r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], spi_write_en_i};
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], spi_read_en_i};
      r_wr_dly  <= r_wr_sync[SYNC_STAGES-1];
      r_rd_dly  <= r_rd_sync[SYNC_STAGES-1];
    end
  end

  assign w_wr_det  = r_wr_sync[SYNC_STAGES-1] & ~r_wr_dly;
  assign w_rd_det  = r_rd_sync[SYNC_STAGES-1] & ~r_rd_dly;
  assign w_spi_det = w_wr_det | w_rd_det;

  // ---------------------------------------------------------------------------
  // Arbitration: decide which requester is issued this cycle
  // ---------------------------------------------------------------------------
  logic                  r_spi_pend;
  logic                  r_spi_we;
  logic [ADDR_WIDTH-1:0] r_spi_addr;
  logic [DATA_WIDTH-1:0] r_spi_wdata;
  logic                  r_overrun;
  logic                  w_spi_take;
  logic                  w_core_take;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_spi;   // 1: SPI won the most recent contended access
`endif

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_spi_take  = 1'b0;
    w_core_take = 1'b0;
    // Nothing is issued while reset is asserted, so the combinational outputs
    // read 0 during reset regardless of core_req_i.
    if (!rst_i && r_state == ST_IDLE) begin
      if (r_spi_pend && core_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
        w_spi_take  = ~r_last_spi;
        w_core_take = r_last_spi;
`else
        w_spi_take  = 1'b1;
`endif
      end else begin
        w_spi_take  = r_spi_pend;
        w_core_take = core_req_i;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_spi <= 1'b0;
    end else if (r_spi_pend && core_req_i && r_state == ST_IDLE) begin
      r_last_spi <= w_spi_take;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // SPI op capture. The address/data buses are sampled directly: the SPI slave
  // holds them stable for many clk periods around its strobe, and the detect
  // pulse arrives well inside that window.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_spi_pend  <= 1'b0;
      r_spi_we    <= 1'b0;
      r_spi_addr  <= '0;
      r_spi_wdata <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_spi_det) begin
        // A new op overwrites the captured one; write wins over a simultaneous
        // read. Either way an op is lost, which is flagged as overrun. An op
        // being issued in this very cycle is not lost.
        r_spi_pend  <= 1'b1;
        r_spi_we    <= w_wr_det;
        r_spi_addr  <= spi_addr_i;
        r_spi_wdata <= spi_write_data_i;
        if ((w_wr_det && w_rd_det) || (r_spi_pend && !w_spi_take)) begin
          r_overrun <= 1'b1;
        end
      end else if (w_spi_take) begin
        r_spi_pend <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and memory-side outputs
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_mem_we;
  logic                  w_mem_re;
  logic                  w_core_gnt;

  always_comb begin
    w_state_next = r_state;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_mem_we     = 1'b0;
    w_mem_re     = 1'b0;
    w_core_gnt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_spi_take) begin
          w_mem_addr = r_spi_addr;
          if (r_spi_we) begin
            w_mem_we    = 1'b1;
            w_mem_wdata = r_spi_wdata;
          end else begin
            w_mem_re     = 1'b1;
            w_state_next = ST_SPI_RD_WAIT;
          end
        end else if (w_core_take) begin
          w_core_gnt = 1'b1;
          w_mem_addr = core_addr_i;
          if (core_we_i) begin
            w_mem_we    = 1'b1;
            w_mem_wdata = core_wdata_i;
          end else begin
            w_mem_re     = 1'b1;
            w_state_next = ST_CORE_RD_WAIT;
          end
        end
      end
      ST_SPI_RD_WAIT:  w_state_next = ST_IDLE;
      ST_CORE_RD_WAIT: w_state_next = ST_IDLE;
      default:         w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and read-data return
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_spi_read_data;
  logic [DATA_WIDTH-1:0] r_core_rdata;
  logic                  r_core_rvalid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= ST_IDLE;
      r_spi_read_data <= '0;
      r_core_rdata    <= '0;
      r_core_rvalid   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      // Data and valid are registered together at the end of the wait state,
      // so rvalid lands two cycles after the grant.
      r_core_rvalid <= (r_state == ST_CORE_RD_WAIT);
      if (r_state == ST_SPI_RD_WAIT) begin
        r_spi_read_data <= mem_rdata_i;
      end
      if (r_state == ST_CORE_RD_WAIT) begin
        r_core_rdata <= mem_rdata_i;
      end
    end
  end

  assign spi_read_data_o = r_spi_read_data;
  assign spi_overrun_o   = r_overrun;
  assign core_gnt_o      = w_core_gnt;
  assign core_rvalid_o   = r_core_rvalid;
  assign core_rdata_o    = r_core_rdata;
  assign mem_addr_o      = w_mem_addr;
  assign mem_wdata_o     = w_mem_wdata;
  assign mem_we_o        = w_mem_we;
  assign mem_re_o        = w_mem_re;

endmodule

// File: tb/tb_spi_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for spi_regfile_arbiter: directed vectors with hand-computed
// expectations, a behavioural single-port memory, and a bus monitor.
// Inputs are driven 1 ns after the rising edge; outputs sampled on the falling
// edge. "cycle i" below is the clk period that starts at the i-th rising edge
// after the stimulus step.
// -----------------------------------------------------------------------------
module tb_spi_regfile_arbiter;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] spi_addr = '0;
  logic [DW-1:0] spi_wdata = '0;
  logic          spi_wr = 1'b0;
  logic          spi_rd = 1'b0;
  logic [DW-1:0] spi_read_data;
  logic          spi_overrun;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_gnt;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  spi_regfile_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .spi_addr_i      (spi_addr),
    .spi_write_data_i(spi_wdata),
    .spi_write_en_i  (spi_wr),
    .spi_read_en_i   (spi_rd),
    .spi_read_data_o (spi_read_data),
    .spi_overrun_o   (spi_overrun),
    .core_req_i      (core_req),
    .core_we_i       (core_we),
    .core_addr_i     (core_addr),
    .core_wdata_i    (core_wdata),
    .core_gnt_o      (core_gnt),
    .core_rvalid_o   (core_rvalid),
    .core_rdata_o    (core_rdata),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_we_o        (mem_we),
    .mem_re_o        (mem_re),
    .mem_rdata_i     (mem_rdata)
  );

  // Behavioural single-port synchronous memory.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Bus monitor: both enables high, or a non-zero idle bus, is illegal.
  int n_both = 0;
  int n_idle_bus = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we && mem_re) n_both++;
      if (!mem_we && !mem_re && (mem_addr != '0 || mem_wdata != '0)) n_idle_bus++;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {spi_read_data, spi_overrun, core_gnt, core_rvalid, core_rdata,
            mem_addr, mem_wdata, mem_we, mem_re};
  endfunction

  // SPI write strobe plus a core write arriving in the SPI issue cycle (3).
  // Returns {gnt, we, addr, wdata} for cycles 3 and 4.
  task automatic contend(input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                         input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         output logic [63:0] h3, output logic [63:0] h4);
    logic got;
    h3 = '0;
    h4 = '0;
    spi_addr  = sa;
    spi_wdata = sd;
    spi_wr    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        core_req = 1'b1; core_we = 1'b1; core_addr = ca; core_wdata = cd;
      end
      if (i == 4) spi_wr = 1'b0;
      @(negedge clk);
      got = core_gnt;
      if (i == 3) h3 = {core_gnt, mem_we, mem_addr, mem_wdata};
      if (i == 4) h4 = {core_gnt, mem_we, mem_addr, mem_wdata};
      adv();
      if (got) core_req = 1'b0;
    end
  endtask

  logic [63:0] acc;
  logic [63:0] h3, h4;
  logic [63:0] hist [10];
  logic [63:0] rv_h [10];
  logic [DW-1:0] srd_h [10];
  logic        ovr_h [10];
  int cnt_we, cnt_re, at_we, at_re;
  logic [63:0] bus_we;

  initial begin
    // ---------------- reset and idle ----------------
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    acc = '0;
    cnt_we = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc = acc | outs();
      if (mem_we || mem_re) cnt_we++;
    end
    check("idle_outputs", acc, 64'h0);
    check("idle_mem_ops", cnt_we, 0);

    // ---------------- core write then read ----------------
    adv();
    core_req = 1'b1; core_we = 1'b1; core_addr = 7'h05; core_wdata = 8'hA5;
    @(negedge clk);
    check("cwr_issue", {core_gnt, mem_we, mem_re, mem_addr, mem_wdata},
          {1'b1, 1'b1, 1'b0, 7'h05, 8'hA5});
    adv();
    core_we = 1'b0;
    @(negedge clk);
    check("crd_issue", {core_gnt, mem_we, mem_re, mem_addr}, {1'b1, 1'b0, 1'b1, 7'h05});
    adv();
    core_req = 1'b0;
    @(negedge clk);
    check("crd_wait", {core_gnt, core_rvalid, mem_re}, 3'b000);
    @(negedge clk);
    check("crd_rvalid", {core_rvalid, core_rdata}, {1'b1, 8'hA5});
    @(negedge clk);
    check("crd_pulse", core_rvalid, 1'b0);

    // ---------------- SPI write, 4-clk strobe ----------------
    adv();
    spi_addr = 7'h12; spi_wdata = 8'h3C; spi_wr = 1'b1;
    cnt_we = 0; at_we = -1; bus_we = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) spi_wr = 1'b0;
      @(negedge clk);
      if (mem_we) begin
        cnt_we++; at_we = i; bus_we = {mem_addr, mem_wdata};
      end
      adv();
    end
    check("spi_wr_count", cnt_we, 1);
    // Enable high in cycle SS+1, so the write commits on edge SS+2 after the rise.
    check("spi_wr_cycle", at_we, SS + 1);
    check("spi_wr_bus", bus_we, {7'h12, 8'h3C});
    check("spi_wr_mem", mem[7'h12], 8'h3C);

    // ---------------- SPI read ----------------
    spi_rd = 1'b1;
    cnt_re = 0; at_re = -1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) spi_rd = 1'b0;
      @(negedge clk);
      srd_h[i] = spi_read_data;
      if (mem_re) begin cnt_re++; at_re = i; end
      adv();
    end
    check("spi_rd_count", cnt_re, 1);
    check("spi_rd_issue", at_re, SS + 1);
    check("spi_rd_before", srd_h[SS+2], 8'h00);
    check("spi_rd_data", srd_h[SS+3], 8'h3C);

    // ---------------- contention ----------------
    contend(7'h30, 8'h5A, 7'h31, 8'h6B, h3, h4);
    check("cont1_first", h3, {1'b0, 1'b1, 7'h30, 8'h5A});
    check("cont1_second", h4, {1'b1, 1'b1, 7'h31, 8'h6B});
    contend(7'h32, 8'h11, 7'h33, 8'h22, h3, h4);
`ifdef ARB_ROUND_ROBIN_EN
    check("cont2_first", h3, {1'b1, 1'b1, 7'h33, 8'h22});
    check("cont2_second", h4, {1'b0, 1'b1, 7'h32, 8'h11});
`else
    check("cont2_first", h3, {1'b0, 1'b1, 7'h32, 8'h11});
    check("cont2_second", h4, {1'b1, 1'b1, 7'h33, 8'h22});
`endif

    // ---------------- overrun during a core read stall ----------------
    // Write 0x20 detected in cycle 2, read 0x05 detected in cycle 3 while the
    // core read granted in cycle 2 holds the FSM in its wait state.
    cnt_we = 0; cnt_re = 0;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin spi_wr = 1'b1; spi_addr = 7'h20; spi_wdata = 8'h77; end
        1: spi_rd = 1'b1;
        2: begin core_req = 1'b1; core_we = 1'b0; core_addr = 7'h12; end
        3: begin core_req = 1'b0; spi_addr = 7'h05; end
        4: spi_wr = 1'b0;
        5: spi_rd = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      ovr_h[i] = spi_overrun;
      srd_h[i] = spi_read_data;
      hist[i]  = {core_gnt, mem_re, mem_addr};
      rv_h[i]  = {core_rvalid, core_rdata};
      if (mem_we) cnt_we++;
      if (mem_re) cnt_re++;
      adv();
    end
    check("ovr_core_gnt", hist[2], {1'b1, 1'b1, 7'h12});
    check("ovr_clear", ovr_h[3], 1'b0);
    check("ovr_set", ovr_h[4], 1'b1);
    check("ovr_spi_issue", hist[4], {1'b0, 1'b1, 7'h05});
    check("ovr_no_write", cnt_we, 0);
    check("ovr_re_count", cnt_re, 2);
    check("ovr_core_rvalid", rv_h[4], {1'b1, 8'h3C});
    check("ovr_spi_rdata", srd_h[6], 8'hA5);
    check("ovr_mem_untouched", mem[7'h20], 8'h00);
    repeat (10) @(negedge clk);
    check("ovr_sticky", spi_overrun, 1'b1);

    // ---------------- reset while in CORE_RD_WAIT ----------------
    adv();
    core_req = 1'b1; core_we = 1'b0; core_addr = 7'h05;
    @(negedge clk);
    check("rst_gnt", core_gnt, 1'b1);
    adv();
    core_req = 1'b0;
    rst = 1'b1;
    adv();
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", outs(), 64'h0);
    @(negedge clk);
    check("rst_no_rvalid", {core_rvalid, outs()}, 64'h0);

    check("mon_both_en", n_both, 0);
    check("mon_idle_bus", n_idle_bus, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_regfile_arbiter.md
Name: spi_regfile_arbiter

Overview:
- Sequences and shares one single-port synchronous register memory between two requesters.
- Requester 1: the SPI slave memory interface. Its strobes originate in the sck domain and are synchronised here.
- Requester 2: a core-side req/gnt port.
- Sits between the SPI slave and the register memory. Owns all mem_* control. Fixed SPI priority by default.

Parameters:
ADDR_WIDTH, 7, memory address width (matches SPI slave)
DATA_WIDTH, 8, memory data width
SYNC_STAGES, 2, flip-flop stages on each SPI strobe synchroniser (min 2)

Ports:
clk_i  input  1  system clock; all logic on rising edge
rst_i  input  1  synchronous reset, active-high
spi_addr_i  input  ADDR_WIDTH  SPI slave address (sck domain, stable around strobe)
spi_write_data_i  input  DATA_WIDTH  SPI slave write data (sck domain)
spi_write_en_i  input  1  SPI write strobe, one sck period wide
spi_read_en_i  input  1  SPI read strobe, one sck period wide
spi_read_data_o  output  DATA_WIDTH  read data returned to SPI slave, held until next SPI read
spi_overrun_o  output  1  sticky: SPI strobe arrived while previous SPI op still pending
core_req_i  input  1  core access request, held until granted
core_we_i  input  1  1 = write, 0 = read
core_addr_i  input  ADDR_WIDTH  core address
core_wdata_i  input  DATA_WIDTH  core write data
core_gnt_o  output  1  combinational grant; access issued this cycle
core_rvalid_o  output  1  one-cycle pulse; core_rdata_o valid
core_rdata_o  output  DATA_WIDTH  core read data
mem_addr_o  output  ADDR_WIDTH  memory address
mem_wdata_o  output  DATA_WIDTH  memory write data
mem_we_o  output  1  memory write enable
mem_re_o  output  1  memory read enable; data on mem_rdata_i one cycle later
mem_rdata_i  input  DATA_WIDTH  memory read data

Behaviour:
- Reset: all outputs 0, both pending flags cleared, FSM to IDLE. Reset mid-access abandons the access and emits no rvalid.
- Synchroniser: each SPI strobe passes through SYNC_STAGES FFs plus one delay FF. A rising edge of the synchronised strobe is one detect pulse.
- Clock requirement: clk_i ≥ 8× sck, so strobes are never missed and read data is ready before the first SDO negedge.
- Capture: on a detect pulse, register spi_addr_i, spi_write_data_i and op type (write/read), and set spi_pend.
  - Write and read detected in the same cycle: write wins, read dropped, spi_overrun_o set.
  - Detect while spi_pend already set: new op overwrites the old one, spi_overrun_o set.
- FSM states: IDLE, SPI_RD_WAIT, CORE_RD_WAIT.
  - IDLE, spi_pend=1: drive mem_* from the captured op and clear spi_pend. Write stays in IDLE; read goes to SPI_RD_WAIT.
  - IDLE, no spi_pend, core_req_i=1: core_gnt_o=1 and drive mem_* from core_*. Write stays in IDLE; read goes to CORE_RD_WAIT.
  - SPI_RD_WAIT: register mem_rdata_i into spi_read_data_o, then go to IDLE.
  - CORE_RD_WAIT: register mem_rdata_i into core_rdata_o, pulse core_rvalid_o the next cycle, go to IDLE.
  - No new access is issued in either WAIT state. Back-to-back writes are allowed every cycle.
- Latency (SPI read, strobe rise to spi_read_data_o update):
  - SYNC_STAGES+3 clk when idle.
  - Worst case SYNC_STAGES+5 clk when a core read is in flight.
- Core write completes in the grant cycle. Core read: core_rvalid_o exactly 2 cycles after grant.
- Starvation: core is starved only while SPI keeps a request pending.
- spi_overrun_o clears only on reset.
- mem_we_o and mem_re_o are never both 1. mem_addr_o/mem_wdata_o are 0 when no access is issued.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: a 1-bit last-winner register is added. When spi_pend and core_req_i contend in IDLE, the requester that did not win the last contended access is granted. Reset state: SPI favoured. Uncontended requests are granted immediately.
- Undefined: fixed priority, SPI always wins.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, no mem_we_o/mem_re_o.
- Core write addr 0x05 data 0xA5, then core read 0x05 -> gnt in the request cycle; core_rvalid_o 2 cycles after read grant with core_rdata_o=0xA5.
- SPI write strobe (4 clk wide) addr 0x12 data 0x3C -> exactly one mem_we_o at addr 0x12/0x3C, SYNC_STAGES+2 cycles after strobe rise; SPI read 0x12 -> spi_read_data_o=0x3C at SYNC_STAGES+3.
- SPI pending and core_req_i in the same IDLE cycle -> SPI issued first, core granted next cycle (fixed); with ARB_ROUND_ROBIN_EN, alternates on repeated contention.
- Second SPI strobe before the first is serviced (force core read stall) -> spi_overrun_o=1 and stays 1; only the second op reaches memory.
- rst_i asserted in CORE_RD_WAIT -> next cycle IDLE, no core_rvalid_o, outputs 0.
